// File: rtl/matrix_mac_stream_pkg.sv
// Shared types and arithmetic helpers for the streaming matrix MAC.
// Helpers work on a wide signed carrier so every accumulator width can share them.
package matrix_mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ACC_WIDTH  = 24;
  localparam int DEF_DIM        = 4;
  localparam int PROD_WIDTH     = 2 * DEF_DATA_WIDTH;
  localparam int IDX_WIDTH      = $clog2(DEF_DIM);

  // Accumulator widths must stay below WIDE_WIDTH - 1 so the carrier sum never wraps.
  localparam int WIDE_WIDTH = 64;
  typedef logic signed [WIDE_WIDTH-1:0] wide_t;

  function automatic int prod_width(input int data_width);
    return 2 * data_width;
  endfunction

  function automatic int idx_width(input int dim);
    return (dim < 2) ? 1 : $clog2(dim);
  endfunction

  function automatic wide_t acc_max(input int width);
    return (wide_t'(1) << (width - 1)) - wide_t'(1);
  endfunction

  function automatic wide_t acc_min(input int width);
    return -acc_max(width) - wide_t'(1);
  endfunction

  function automatic logic ovf_detect(input wide_t a, input wide_t b, input int width);
    wide_t sum;
    sum = a + b;
    return (sum > acc_max(width)) || (sum < acc_min(width));
  endfunction

  // Wrapping re-sign-extends the low `width` bits of the exact sum.
  function automatic wide_t sat_add(input wide_t a, input wide_t b, input int width,
                                    input logic saturate);
    wide_t sum;
    wide_t mask;
    wide_t low;
    sum  = a + b;
    mask = (wide_t'(1) << width) - wide_t'(1);
    low  = sum & mask;
    if (!ovf_detect(a, b, width)) begin
      return sum;
    end
    if (saturate) begin
      return (sum > acc_max(width)) ? acc_max(width) : acc_min(width);
    end
    return low[width-1] ? (low | ~mask) : low;
  endfunction

endpackage

// File: rtl/matrix_mac_stream_if.sv
// Operand/result handshake bundle of the matrix MAC; master drives operands, slave is the engine.
interface matrix_mac_stream_if
  import matrix_mac_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int DIM        = DEF_DIM
);

  localparam int IW = idx_width(DIM);

  logic                      clear;
  logic                      in_valid;
  logic                      in_ready;
  logic [DIM*DATA_WIDTH-1:0] in_a;
  logic [DIM*DATA_WIDTH-1:0] in_b;
  logic                      in_first;
  logic                      in_last;
  logic                      out_valid;
  logic                      out_ready;
  logic [DIM*ACC_WIDTH-1:0]  out_row;
  logic [IW-1:0]             out_row_idx;
  logic                      overflow;

  modport master (
    output clear, in_valid, in_a, in_b, in_first, in_last, out_ready,
    input  in_ready, out_valid, out_row, out_row_idx, overflow
  );

  modport slave (
    input  clear, in_valid, in_a, in_b, in_first, in_last, out_ready,
    output in_ready, out_valid, out_row, out_row_idx, overflow
  );

endinterface

// File: rtl/matrix_mac_stream_mac_cell.sv
// One accumulator element: signed multiply, overwrite/accumulate, saturate or wrap,
// and a per-tile sticky overflow bit.
module mac_cell
  import matrix_mac_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int SATURATE   = 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        i_clear,
  input  logic                        i_beat,
  input  logic                        i_first,
  input  logic signed [DATA_WIDTH-1:0] i_a,
  input  logic signed [DATA_WIDTH-1:0] i_b,
  output logic signed [ACC_WIDTH-1:0]  o_acc,
  output logic                        o_ovf
);

  localparam int PW = prod_width(DATA_WIDTH);

  logic signed [PW-1:0]        w_prod;
  logic signed [ACC_WIDTH-1:0] w_sum;
  wide_t                       w_base;
  logic                        w_add_ovf;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic                        r_ovf;

  assign w_prod    = PW'(i_a) * PW'(i_b);
  assign w_base    = i_first ? '0 : wide_t'(r_acc);
  assign w_sum     = ACC_WIDTH'(sat_add(w_base, wide_t'(w_prod), ACC_WIDTH, SATURATE != 0));
  assign w_add_ovf = ovf_detect(w_base, wide_t'(w_prod), ACC_WIDTH);

  // A first beat restarts the sticky flag, but its own overflow still counts.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (i_clear) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (i_beat) begin
      r_acc <= w_sum;
      r_ovf <= w_add_ovf | (r_ovf & ~i_first);
    end
  end

  assign o_acc = r_acc;
  assign o_ovf = r_ovf;

endmodule

// File: rtl/matrix_mac_stream.sv
// DIM x DIM outer-product MAC: accumulates one A column / B row per beat,
// then drains C one row per output handshake.
module matrix_mac_stream
  import matrix_mac_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int DIM        = DEF_DIM,
  parameter int SATURATE   = 1
) (
  input logic                 clock,
  input logic                 reset,
  matrix_mac_stream_if.slave  bus
);

  localparam int IW = idx_width(DIM);

  state_t                      r_state;
  state_t                      w_next_state;
  logic [IW-1:0]               r_row_idx;
  logic [IW-1:0]               w_next_row_idx;
  logic                        w_in_ready;
  logic                        w_out_valid;
  logic                        w_beat;
  logic                        w_last_row;
  logic signed [ACC_WIDTH-1:0] w_acc [DIM][DIM];
  logic [DIM*DIM-1:0]          w_ovf;
  logic [DIM*ACC_WIDTH-1:0]    w_out_row;

  assign w_beat     = bus.in_valid && w_in_ready && !bus.clear;
  assign w_last_row = (r_row_idx == IW'(DIM - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_row_idx <= '0;
    end else begin
      r_state   <= w_next_state;
      r_row_idx <= w_next_row_idx;
    end
  end

  // clear overrides any beat or row handshake presented in the same cycle.
  always_comb begin
    w_next_state   = r_state;
    w_next_row_idx = r_row_idx;
    w_in_ready     = 1'b0;
    w_out_valid    = 1'b0;
    case (r_state)
      IDLE, ACCUM: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_next_state = bus.in_last ? DRAIN : ACCUM;
        end
      end
      DRAIN: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          if (w_last_row) begin
            w_next_state   = IDLE;
            w_next_row_idx = '0;
          end else begin
            w_next_row_idx = r_row_idx + IW'(1);
          end
        end
      end
      default: begin
        w_next_state   = IDLE;
        w_next_row_idx = '0;
      end
    endcase
    if (bus.clear) begin
      w_next_state   = IDLE;
      w_next_row_idx = '0;
    end
  end

  for (genvar gi = 0; gi < DIM; gi++) begin : g_row
    for (genvar gj = 0; gj < DIM; gj++) begin : g_col
      mac_cell #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .SATURATE   (SATURATE)
      ) u_cell (
        .clock   (clock),
        .reset   (reset),
        .i_clear (bus.clear),
        .i_beat  (w_beat),
        .i_first (bus.in_first),
        .i_a     (bus.in_a[gi*DATA_WIDTH +: DATA_WIDTH]),
        .i_b     (bus.in_b[gj*DATA_WIDTH +: DATA_WIDTH]),
        .o_acc   (w_acc[gi][gj]),
        .o_ovf   (w_ovf[gi*DIM + gj])
      );
    end
  end

  // The presented row comes straight off the accumulators, so it holds while stalled.
  always_comb begin
    w_out_row = '0;
    for (int j = 0; j < DIM; j++) begin
      w_out_row[j*ACC_WIDTH +: ACC_WIDTH] = w_acc[r_row_idx][j];
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = w_out_valid;
  assign bus.out_row     = w_out_row;
  assign bus.out_row_idx = r_row_idx;
  assign bus.overflow    = |w_ovf;

endmodule

// File: tb/tb_matrix_mac_stream.sv
// Directed bench for matrix_mac_stream: identity, multi-tile accumulation, back-pressure,
// clear collision, saturate/wrap corner and asynchronous reset during drain.
module tb_matrix_mac_stream;

  localparam int DW  = 8;
  localparam int AW  = 24;
  localparam int SAW = 16;
  localparam int DIM = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   nAsserts  = 0;
  int   nFailures = 0;

  always #5 clock = ~clock;

  matrix_mac_stream_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW),  .DIM(DIM)) bus ();
  matrix_mac_stream_if #(.DATA_WIDTH(DW), .ACC_WIDTH(SAW), .DIM(DIM)) satBus ();
  matrix_mac_stream_if #(.DATA_WIDTH(DW), .ACC_WIDTH(SAW), .DIM(DIM)) wrapBus ();

  matrix_mac_stream #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .DIM(DIM), .SATURATE(1)) dut (
    .clock (clock), .reset (reset), .bus (bus));
  matrix_mac_stream #(.DATA_WIDTH(DW), .ACC_WIDTH(SAW), .DIM(DIM), .SATURATE(1)) dutSat (
    .clock (clock), .reset (reset), .bus (satBus));
  matrix_mac_stream #(.DATA_WIDTH(DW), .ACC_WIDTH(SAW), .DIM(DIM), .SATURATE(0)) dutWrap (
    .clock (clock), .reset (reset), .bus (wrapBus));

  // The 16-bit pair sees identical operands so saturate and wrap can be compared side by side.
  logic              sValid, sFirst, sLast, sOutReady;
  logic [DIM*DW-1:0] sA, sB;
  assign satBus.clear      = 1'b0;
  assign satBus.in_valid   = sValid;
  assign satBus.in_a       = sA;
  assign satBus.in_b       = sB;
  assign satBus.in_first   = sFirst;
  assign satBus.in_last    = sLast;
  assign satBus.out_ready  = sOutReady;
  assign wrapBus.clear     = 1'b0;
  assign wrapBus.in_valid  = sValid;
  assign wrapBus.in_a      = sA;
  assign wrapBus.in_b      = sB;
  assign wrapBus.in_first  = sFirst;
  assign wrapBus.in_last   = sLast;
  assign wrapBus.out_ready = sOutReady;

  logic [DIM*AW-1:0] expRows [DIM];

  function automatic logic [DIM*DW-1:0] packOps(input int e0, input int e1, input int e2,
                                                input int e3);
    return {DW'(e3), DW'(e2), DW'(e1), DW'(e0)};
  endfunction

  function automatic logic [DIM*AW-1:0] packRow(input int e0, input int e1, input int e2,
                                                input int e3);
    return {AW'(e3), AW'(e2), AW'(e1), AW'(e0)};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    nAsserts++;
    assert (observed === expected) else begin
      nFailures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [DIM*DW-1:0] a, input logic [DIM*DW-1:0] b,
                               input logic first, input logic last);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_first = first;
    bus.in_last  = last;
    tick();
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // A = I, B[k][j] = 4k+j, so C must equal B row for row.
  task automatic identityTile();
    for (int k = 0; k < DIM; k++) begin
      applyStimulus(packOps(k == 0 ? 1 : 0, k == 1 ? 1 : 0, k == 2 ? 1 : 0, k == 3 ? 1 : 0),
                    packOps(4*k, 4*k + 1, 4*k + 2, 4*k + 3), k == 0, k == DIM - 1);
    end
    for (int r = 0; r < DIM; r++) expRows[r] = packRow(4*r, 4*r + 1, 4*r + 2, 4*r + 3);
  endtask

  task automatic drainCheck(input string tag);
    for (int r = 0; r < DIM; r++) begin
      checkOutput($sformatf("%s valid%0d", tag, r), bus.out_valid, 1);
      checkOutput($sformatf("%s idx%0d", tag, r), bus.out_row_idx, r);
      checkOutput($sformatf("%s row%0d", tag, r), bus.out_row, expRows[r]);
      tick();
    end
    checkOutput({tag, " valid after drain"}, bus.out_valid, 0);
    checkOutput({tag, " ready after drain"}, bus.in_ready, 1);
  endtask

  initial begin
    int r;
    int c;
    logic [DIM*DW-1:0] ones;
    ones          = packOps(1, 1, 1, 1);
    bus.clear     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_first  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    sValid = 1'b0; sFirst = 1'b0; sLast = 1'b0; sOutReady = 1'b1;
    sA = '0; sB = '0;

    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    checkOutput("reset in_ready", bus.in_ready, 1);
    checkOutput("reset out_valid", bus.out_valid, 0);
    checkOutput("reset out_row", bus.out_row, 0);
    checkOutput("reset row_idx", bus.out_row_idx, 0);
    checkOutput("reset overflow", bus.overflow, 0);

    identityTile();
    drainCheck("identity");

    for (int k = 0; k < DIM; k++) applyStimulus(ones, ones, k == 0, k == DIM - 1);
    for (int i = 0; i < DIM; i++) expRows[i] = packRow(4, 4, 4, 4);
    drainCheck("acc pass1");
    for (int k = 0; k < DIM; k++) applyStimulus(ones, ones, 1'b0, k == DIM - 1);
    for (int i = 0; i < DIM; i++) expRows[i] = packRow(8, 8, 8, 8);
    drainCheck("acc pass2");
    checkOutput("acc overflow", bus.overflow, 0);

    // Ready pattern 1,0,0,1,0,0,...: each row must hold until its handshake.
    identityTile();
    r = 0;
    c = 0;
    while (r < DIM && c < 40) begin
      bus.out_ready = (c % 3 == 0);
      checkOutput($sformatf("bp valid c%0d", c), bus.out_valid, 1);
      checkOutput($sformatf("bp in_ready c%0d", c), bus.in_ready, 0);
      checkOutput($sformatf("bp idx c%0d", c), bus.out_row_idx, r);
      checkOutput($sformatf("bp row c%0d", c), bus.out_row, expRows[r]);
      tick();
      if (bus.out_ready) r++;
      c++;
    end
    bus.out_ready = 1'b1;
    checkOutput("bp rows consumed", r, DIM);
    checkOutput("bp cycles", c, 10);
    checkOutput("bp valid after", bus.out_valid, 0);
    checkOutput("bp ready after", bus.in_ready, 1);

    applyStimulus(ones, ones, 1'b1, 1'b0);
    bus.clear    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_a     = ones;
    bus.in_b     = ones;
    bus.in_last  = 1'b1;
    tick();
    bus.clear    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    checkOutput("clear no drain", bus.out_valid, 0);
    checkOutput("clear in_ready", bus.in_ready, 1);
    checkOutput("clear overflow", bus.overflow, 0);
    applyStimulus('0, '0, 1'b0, 1'b1);
    for (int i = 0; i < DIM; i++) expRows[i] = '0;
    drainCheck("clear");

    // -128 * -128 = 16384 per beat; three beats exceed the 16-bit range on the second add.
    sA = packOps(-128, -128, -128, -128);
    sB = sA;
    sValid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sFirst = (k == 0);
      sLast  = (k == 2);
      tick();
    end
    sValid = 1'b0; sFirst = 1'b0; sLast = 1'b0;
    for (int i = 0; i < DIM; i++) begin
      checkOutput($sformatf("sat valid%0d", i), satBus.out_valid, 1);
      checkOutput($sformatf("sat idx%0d", i), satBus.out_row_idx, i);
      checkOutput($sformatf("sat row%0d", i), satBus.out_row, 64'h7fff_7fff_7fff_7fff);
      checkOutput($sformatf("sat ovf%0d", i), satBus.overflow, 1);
      checkOutput($sformatf("wrap row%0d", i), wrapBus.out_row, 64'hc000_c000_c000_c000);
      checkOutput($sformatf("wrap ovf%0d", i), wrapBus.overflow, 1);
      tick();
    end
    checkOutput("sat drained", satBus.out_valid, 0);

    sA = packOps(1, 1, 1, 1);
    sB = sA;
    sValid = 1'b1; sFirst = 1'b1; sLast = 1'b1;
    tick();
    sValid = 1'b0; sFirst = 1'b0; sLast = 1'b0;
    checkOutput("sat first clears ovf", satBus.overflow, 0);
    checkOutput("wrap first clears ovf", wrapBus.overflow, 0);
    checkOutput("sat restart row", satBus.out_row, 64'h0001_0001_0001_0001);
    repeat (DIM) tick();
    checkOutput("sat restart drained", satBus.out_valid, 0);

    identityTile();
    tick();
    tick();
    checkOutput("pre-reset idx", bus.out_row_idx, 2);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async reset valid", bus.out_valid, 0);
    checkOutput("async reset row", bus.out_row, 0);
    checkOutput("async reset idx", bus.out_row_idx, 0);
    checkOutput("async reset in_ready", bus.in_ready, 1);
    @(posedge clock);
    #1;
    reset = 1'b1;
    applyStimulus(ones, ones, 1'b1, 1'b1);
    for (int i = 0; i < DIM; i++) expRows[i] = packRow(1, 1, 1, 1);
    drainCheck("post reset");

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFailures);
    $finish;
  end

endmodule
